// File: rtl/uart_cmd_parser.sv
// Turns the UART receiver byte stream into SYNC/CMD/LEN/payload/XOR-checksum packets.
// Writes payload bytes to an external buffer and reports each packet as good or aborted.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int        TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_frame_error,
  output logic          pay_we,
  output logic [AW-1:0] pay_addr,
  output logic [7:0]    pay_wdata,
  output logic [7:0]    cmd_out,
  output logic [7:0]    len_out,
  output logic          pkt_valid,
  output logic          pkt_error,
  output logic [1:0]    err_code,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_LENGTH  = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t        state_q, state_d;
  logic [7:0]    csum_q, csum_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    cmd_sh_q, cmd_sh_d;
  logic [7:0]    len_sh_q, len_sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pay_we_q, pay_we_d;
  logic [AW-1:0] pay_addr_q, pay_addr_d;
  logic [7:0]    pay_wdata_q, pay_wdata_d;
  logic [7:0]    cmd_out_q, cmd_out_d;
  logic [7:0]    len_out_q, len_out_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic          pkt_error_q, pkt_error_d;
  logic [1:0]    err_code_q, err_code_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      csum_q      <= '0;
      idx_q       <= '0;
      cmd_sh_q    <= '0;
      len_sh_q    <= '0;
      tmo_q       <= '0;
      pay_we_q    <= 1'b0;
      pay_addr_q  <= '0;
      pay_wdata_q <= '0;
      cmd_out_q   <= '0;
      len_out_q   <= '0;
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      cmd_sh_q    <= cmd_sh_d;
      len_sh_q    <= len_sh_d;
      tmo_q       <= tmo_d;
      pay_we_q    <= pay_we_d;
      pay_addr_q  <= pay_addr_d;
      pay_wdata_q <= pay_wdata_d;
      cmd_out_q   <= cmd_out_d;
      len_out_q   <= len_out_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_error_q <= pkt_error_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    cmd_sh_d    = cmd_sh_q;
    len_sh_d    = len_sh_q;
    pay_we_d    = 1'b0;
    pay_addr_d  = pay_addr_q;
    pay_wdata_d = pay_wdata_q;
    cmd_out_d   = cmd_out_q;
    len_out_d   = len_out_q;
    pkt_valid_d = 1'b0;
    pkt_error_d = 1'b0;
    err_code_d  = err_code_q;

    if (state_q == ST_HUNT || rx_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    // Frame error beats a same-cycle byte; a byte beats the timeout deadline.
    if (state_q != ST_HUNT && rx_frame_error) begin
      state_d     = ST_HUNT;
      idx_d       = '0;
      pkt_error_d = 1'b1;
      err_code_d  = ERR_FRAME;
    end else if (rx_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          cmd_sh_d = rx_data;
          csum_d   = rx_data;
          state_d  = ST_LEN;
        end
        ST_LEN: begin
          len_sh_d = rx_data;
          csum_d   = csum_q ^ rx_data;
          if ({1'b0, rx_data} > MAX_LEN_W) begin
            state_d     = ST_HUNT;
            idx_d       = '0;
            pkt_error_d = 1'b1;
            err_code_d  = ERR_LENGTH;
          end else if (rx_data == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          pay_we_d    = 1'b1;
          pay_wdata_d = rx_data;
          pay_addr_d  = idx_q;
          csum_d      = csum_q ^ rx_data;
          if (8'(idx_q) == len_sh_q - 8'd1) begin
            state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
        ST_CSUM: begin
          state_d = ST_HUNT;
          idx_d   = '0;
          if (rx_data == csum_q) begin
            pkt_valid_d = 1'b1;
            cmd_out_d   = cmd_sh_q;
            len_out_d   = len_sh_q;
          end else begin
            pkt_error_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
        default: begin
          state_d = ST_HUNT;
          idx_d   = '0;
        end
      endcase
    end else if (state_q != ST_HUNT && tmo_q == TMO_LIMIT) begin
      state_d     = ST_HUNT;
      idx_d       = '0;
      pkt_error_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  assign pay_we    = pay_we_q;
  assign pay_addr  = pay_addr_q;
  assign pay_wdata = pay_wdata_q;
  assign cmd_out   = cmd_out_q;
  assign len_out   = len_out_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_error = pkt_error_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: good, zero-length, bad-checksum, oversize, timeout,
// frame-error and mid-packet-reset packets with hand-computed expectations.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 20;
  localparam int AW      = 4;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_frame_error;
  logic          pay_we;
  logic [AW-1:0] pay_addr;
  logic [7:0]    pay_wdata;
  logic [7:0]    cmd_out;
  logic [7:0]    len_out;
  logic          pkt_valid;
  logic          pkt_error;
  logic [1:0]    err_code;
  logic          busy;

  int totalChecks = 0;
  int badChecks   = 0;
  int payWeCount  = 0;
  int validCount  = 0;
  int errorCount  = 0;
  int snapWe, snapValid, snapError;
  logic sawEarlyError;

  uart_cmd_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_error (rx_frame_error),
    .pay_we         (pay_we),
    .pay_addr       (pay_addr),
    .pay_wdata      (pay_wdata),
    .cmd_out        (cmd_out),
    .len_out        (len_out),
    .pkt_valid      (pkt_valid),
    .pkt_error      (pkt_error),
    .err_code       (err_code),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters read the registered outputs just before each edge updates them.
  always @(posedge clk) begin
    if (pay_we)    payWeCount <= payWeCount + 1;
    if (pkt_valid) validCount <= validCount + 1;
    if (pkt_error) errorCount <= errorCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One byte on the rx interface; returns at the negedge after the byte was sampled.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settleCounts();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    rx_data        = 8'h00;
    rx_valid       = 1'b0;
    rx_frame_error = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(pkt_valid), 32'd0);
    checkOutput("reset_error", 32'(pkt_error), 32'd0);
    checkOutput("reset_errcode", 32'(err_code), 32'd0);
    checkOutput("reset_cmd", 32'(cmd_out), 32'd0);
    checkOutput("reset_len", 32'(len_out), 32'd0);
    checkOutput("reset_paywe", 32'(pay_we), 32'd0);
    checkOutput("reset_payaddr", 32'(pay_addr), 32'd0);
    reset = 1'b0;

    // Good packet A5 10 02 11 22 21 (10^02^11^22 = 21)
    applyStimulus(8'h33);
    checkOutput("hunt_ignore_busy", 32'(busy), 32'd0);
    applyStimulus(8'hA5);
    checkOutput("sync_busy", 32'(busy), 32'd1);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    checkOutput("good_we0", 32'(pay_we), 32'd1);
    checkOutput("good_addr0", 32'(pay_addr), 32'd0);
    checkOutput("good_data0", 32'(pay_wdata), 32'h11);
    applyStimulus(8'h22);
    checkOutput("good_we1", 32'(pay_we), 32'd1);
    checkOutput("good_addr1", 32'(pay_addr), 32'd1);
    checkOutput("good_data1", 32'(pay_wdata), 32'h22);
    applyStimulus(8'h21);
    checkOutput("good_valid", 32'(pkt_valid), 32'd1);
    checkOutput("good_error", 32'(pkt_error), 32'd0);
    checkOutput("good_cmd", 32'(cmd_out), 32'h10);
    checkOutput("good_len", 32'(len_out), 32'h02);
    checkOutput("good_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("good_valid_pulse", 32'(pkt_valid), 32'd0);

    // Zero length A5 07 00 07
    settleCounts();
    snapWe = payWeCount;
    applyStimulus(8'hA5);
    applyStimulus(8'h07);
    applyStimulus(8'h00);
    applyStimulus(8'h07);
    checkOutput("zero_valid", 32'(pkt_valid), 32'd1);
    checkOutput("zero_cmd", 32'(cmd_out), 32'h07);
    checkOutput("zero_len", 32'(len_out), 32'h00);
    settleCounts();
    checkOutput("zero_no_paywe", 32'(payWeCount - snapWe), 32'd0);

    // Bad checksum A5 10 02 11 22 20
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h20);
    checkOutput("badcs_error", 32'(pkt_error), 32'd1);
    checkOutput("badcs_valid", 32'(pkt_valid), 32'd0);
    checkOutput("badcs_code", 32'(err_code), 32'd0);
    checkOutput("badcs_cmd_kept", 32'(cmd_out), 32'h07);
    checkOutput("badcs_len_kept", 32'(len_out), 32'h00);

    // Oversize LEN 0x11, then back-to-back A5 01 00 01
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    checkOutput("len_error", 32'(pkt_error), 32'd1);
    checkOutput("len_code", 32'(err_code), 32'd1);
    checkOutput("len_busy", 32'(busy), 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    checkOutput("after_len_valid", 32'(pkt_valid), 32'd1);
    checkOutput("after_len_cmd", 32'(cmd_out), 32'h01);
    checkOutput("after_len_code_held", 32'(err_code), 32'd1);

    // Maximum length 16 is accepted; last byte lands at address 15
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    for (int i = 0; i < MAX_LEN; i++) applyStimulus(8'hA5);
    checkOutput("max_addr", 32'(pay_addr), 32'd15);
    checkOutput("max_busy", 32'(busy), 32'd1);
    applyStimulus(8'h12);
    checkOutput("max_valid", 32'(pkt_valid), 32'd1);
    checkOutput("max_len", 32'(len_out), 32'h10);

    // Timeout: idle past the deadline after A5 10
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    sawEarlyError = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (pkt_error || !busy) sawEarlyError = 1'b1;
    end
    checkOutput("tmo_not_early", 32'(sawEarlyError), 32'd0);
    @(negedge clk);
    checkOutput("tmo_error", 32'(pkt_error), 32'd1);
    checkOutput("tmo_code", 32'(err_code), 32'd3);
    checkOutput("tmo_busy", 32'(busy), 32'd0);

    // Byte arriving on the deadline cycle keeps the packet alive
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    settleCounts();
    snapError = errorCount;
    for (int i = 0; i < TMO - 1; i++) @(negedge clk);
    applyStimulus(8'h00);
    checkOutput("deadline_no_error", 32'(pkt_error), 32'd0);
    checkOutput("deadline_busy", 32'(busy), 32'd1);
    applyStimulus(8'h10);
    checkOutput("deadline_valid", 32'(pkt_valid), 32'd1);
    checkOutput("deadline_cmd", 32'(cmd_out), 32'h10);
    settleCounts();
    checkOutput("deadline_err_count", 32'(errorCount - snapError), 32'd0);

    // Frame error during PAYLOAD, coinciding with a byte that must be dropped
    snapWe = payWeCount;
    applyStimulus(8'hA5);
    applyStimulus(8'h05);
    applyStimulus(8'h03);
    applyStimulus(8'hAA);
    @(negedge clk);
    rx_data        = 8'hBB;
    rx_valid       = 1'b1;
    rx_frame_error = 1'b1;
    @(negedge clk);
    rx_valid       = 1'b0;
    rx_frame_error = 1'b0;
    checkOutput("frame_error", 32'(pkt_error), 32'd1);
    checkOutput("frame_code", 32'(err_code), 32'd2);
    checkOutput("frame_no_we", 32'(pay_we), 32'd0);
    checkOutput("frame_busy", 32'(busy), 32'd0);
    settleCounts();
    checkOutput("frame_we_count", 32'(payWeCount - snapWe), 32'd1);

    // Frame error while hunting is ignored
    snapError = errorCount;
    @(negedge clk);
    rx_frame_error = 1'b1;
    @(negedge clk);
    rx_frame_error = 1'b0;
    settleCounts();
    checkOutput("hunt_frame_ignored", 32'(errorCount - snapError), 32'd0);

    // Reset mid-PAYLOAD, then a good packet A5 30 01 44 75
    settleCounts();
    snapValid = validCount;
    snapError = errorCount;
    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    applyStimulus(8'h03);
    applyStimulus(8'h01);
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_cmd", 32'(cmd_out), 32'd0);
    checkOutput("midrst_errcode", 32'(err_code), 32'd0);
    checkOutput("midrst_paywe", 32'(pay_we), 32'd0);
    checkOutput("midrst_paydata", 32'(pay_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    settleCounts();
    checkOutput("midrst_no_pulse", 32'((validCount - snapValid) + (errorCount - snapError)), 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h30);
    applyStimulus(8'h01);
    applyStimulus(8'h44);
    checkOutput("post_rst_addr", 32'(pay_addr), 32'd0);
    checkOutput("post_rst_data", 32'(pay_wdata), 32'h44);
    applyStimulus(8'h75);
    checkOutput("post_rst_valid", 32'(pkt_valid), 32'd1);
    checkOutput("post_rst_cmd", 32'(cmd_out), 32'h30);
    checkOutput("post_rst_len", 32'(len_out), 32'h01);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
